// File: rtl/leaf_stream_buffer.sv
// leaf_stream_buffer
// Bank of NUM_CH independent first-word-fall-through FIFOs, each
// 2**DEPTH_BITS entries deep, with valid/ack handshakes on both sides.
// Each channel reports its free-entry count and keeps a sticky overflow
// flag that is set when upstream offers data while the channel is full.
//
// Optional feature: define LEAF_STREAM_BUFFER_STATS_EN to add the stall_cnt
// output. Each 16-bit slice counts cycles in which a channel holds data
// that downstream does not accept. The count saturates at 0xFFFF.
//
// Upstream ready (ack_out), downstream valid (vld_out), freespace and
// ovf_err are all flops. They are computed from the next occupancy, so
// ack_in and vld_in never reach these outputs through combinational logic.
// Payload storage is not reset. Reset only clears pointers, counters and
// flags, so any buffered word becomes unreachable.

module leaf_stream_buffer #(
    parameter int NUM_CH       = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 3
) (
    input  logic                              clk_user,
    input  logic                              reset_n,
    input  logic [NUM_CH*PAYLOAD_BITS-1:0]    din,
    input  logic [NUM_CH-1:0]                 vld_in,
    output logic [NUM_CH-1:0]                 ack_out,
    output logic [NUM_CH*PAYLOAD_BITS-1:0]    dout,
    output logic [NUM_CH-1:0]                 vld_out,
    input  logic [NUM_CH-1:0]                 ack_in,
    output logic [NUM_CH*(DEPTH_BITS+1)-1:0]  freespace,
    output logic [NUM_CH-1:0]                 ovf_err
`ifdef LEAF_STREAM_BUFFER_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]              stall_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch

        logic [PAYLOAD_BITS-1:0] mem_r [DEPTH];
        logic [DEPTH_BITS-1:0]   wr_ptr_r;
        logic [DEPTH_BITS-1:0]   rd_ptr_r;
        logic [CW-1:0]           count_r;
        logic [CW-1:0]           count_nxt_s;
        logic [CW-1:0]           free_r;
        logic                    ack_r;
        logic                    vld_r;
        logic                    ovf_r;
        logic                    wr_en_s;
        logic                    rd_en_s;

        // Handshake decode: transfers happen only against the registered flags.
        always_comb begin
            wr_en_s = vld_in[g] & ack_r;
            rd_en_s = vld_r & ack_in[g];
        end

        // Next occupancy: write alone adds one, read alone removes one, both cancel.
        always_comb begin
            count_nxt_s = count_r;
            case ({wr_en_s, rd_en_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
        end

        // Pointer, occupancy, status flag and overflow state, cleared asynchronously.
        always_ff @(posedge clk_user or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
                free_r   <= DEPTH_C;
                ack_r    <= 1'b1;
                vld_r    <= 1'b0;
                ovf_r    <= 1'b0;
            end else begin
                if (wr_en_s) begin
                    wr_ptr_r <= wr_ptr_r + DEPTH_BITS'(1);
                end
                if (rd_en_s) begin
                    rd_ptr_r <= rd_ptr_r + DEPTH_BITS'(1);
                end
                count_r <= count_nxt_s;
                free_r  <= DEPTH_C - count_nxt_s;
                ack_r   <= (count_nxt_s != DEPTH_C);
                vld_r   <= (count_nxt_s != CW'(0));
                if (vld_in[g] && !ack_r) begin
                    ovf_r <= 1'b1;
                end
            end
        end

        // Payload storage, deliberately left out of reset.
        always_ff @(posedge clk_user) begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= din[g*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end

        assign ack_out[g]                         = ack_r;
        assign vld_out[g]                         = vld_r;
        assign ovf_err[g]                         = ovf_r;
        assign freespace[g*CW +: CW]              = free_r;
        assign dout[g*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_r[rd_ptr_r];

`ifdef LEAF_STREAM_BUFFER_STATS_EN
        logic [15:0] stall_r;

        // Saturating count of cycles with data waiting and no downstream accept.
        always_ff @(posedge clk_user or negedge reset_n) begin
            if (!reset_n) begin
                stall_r <= 16'h0000;
            end else if (vld_r && !ack_in[g] && (stall_r != 16'hFFFF)) begin
                stall_r <= stall_r + 16'h0001;
            end else begin
                stall_r <= stall_r;
            end
        end

        assign stall_cnt[g*16 +: 16] = stall_r;
`endif
    end

endmodule
